// File: rtl/mem_wr_responder_pkg.sv
// Shared constants and state encoding for the frame-buffer write responder.
package mem_wr_responder_pkg;

  localparam int BURST_LEN          = 4;
  localparam int BEAT_W             = $clog2(BURST_LEN);
  localparam int ADDR_W             = 23;
  localparam int DEF_REFRESH_PERIOD = 780;
  localparam int DEF_REFRESH_LEN    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_DATA    = 2'd2,
    ST_REFRESH = 2'd3
  } state_t;

endpackage

// File: rtl/mem_refresh_timer.sv
// Free-running refresh interval counter; raises a sticky pending flag on each wrap.
module mem_refresh_timer #(
  parameter int PERIOD = 780
) (
  input  logic mem_clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_pending
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             w_wrap;

  assign w_wrap    = (r_cnt == LAST_CNT);
  assign o_pending = r_pending;

  // Clear beats a coincident wrap so a second refresh never queues behind the first.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (i_clr)
        r_pending <= 1'b0;
      else if (w_wrap)
        r_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wr_responder.sv
// Accepts 4-word write bursts from a writer and stores them to the frame-buffer
// RAM port, yielding to periodic refresh windows between bursts.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | ready; refresh has priority over a new request
//   ST_ACK     | one-cycle grant, fetch strobe for word 0 is on mem_ack
//   ST_DATA    | beats 0..3, one word captured and written per cycle
//   ST_REFRESH | REFRESH_LEN cycles with mem_idle low
module mem_wr_responder
  import mem_wr_responder_pkg::*;
#(
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int REFRESH_LEN    = DEF_REFRESH_LEN
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        mem_wr_req,
  input  logic [24:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  output logic        mem_idle,
  output logic        mem_ack,
  output logic        mem_data_next,
  output logic        ram_we,
  output logic [22:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [15:0] bursts_done
);

  localparam int REF_W = (REFRESH_LEN > 1) ? $clog2(REFRESH_LEN) : 1;
  localparam logic [REF_W-1:0]  LAST_REF  = REF_W'(REFRESH_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] NEXT_LAST = BEAT_W'(BURST_LEN - 2);

  state_t              r_state;
  logic [BEAT_W-1:0]   r_beat;
  logic [REF_W-1:0]    r_ref_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic                r_idle;
  logic                r_ack;
  logic                r_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [15:0]         r_bursts;

  logic                w_pending;
  logic                w_ref_clr;
  logic [1:0]          w_unused_addr_lsb;

  assign w_unused_addr_lsb = mem_wr_addr[1:0];

  // Pending clears on the same edge the FSM commits to ST_REFRESH.
  assign w_ref_clr = w_pending &&
                     ((r_state == ST_IDLE) ||
                      (r_state == ST_DATA && r_beat == LAST_BEAT));

  mem_refresh_timer #(
    .PERIOD (REFRESH_PERIOD)
  ) u_refresh_timer (
    .mem_clk   (mem_clk),
    .rst_n     (rst_n),
    .i_clr     (w_ref_clr),
    .o_pending (w_pending)
  );

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_ref_cnt <= '0;
      r_base    <= '0;
      r_idle    <= 1'b1;
      r_ack     <= 1'b0;
      r_next    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_bursts  <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_next <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state   <= ST_REFRESH;
            r_ref_cnt <= '0;
            r_idle    <= 1'b0;
          end else if (mem_wr_req) begin
            r_base  <= mem_wr_addr[24:2];
            r_state <= ST_ACK;
            r_idle  <= 1'b0;
            r_ack   <= 1'b1;
          end
        end
        ST_ACK: begin
          r_beat  <= '0;
          r_next  <= 1'b1;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          // Word k arrives the cycle after its strobe, so it is captured in beat k.
          r_we    <= 1'b1;
          r_addr  <= r_base + ADDR_W'(r_beat);
          r_wdata <= mem_wr_data;
          r_beat  <= r_beat + 1'b1;
          if (r_beat < NEXT_LAST)
            r_next <= 1'b1;
          if (r_beat == LAST_BEAT) begin
            r_bursts <= r_bursts + 16'd1;
            if (w_pending) begin
              r_state   <= ST_REFRESH;
              r_ref_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_idle  <= 1'b1;
            end
          end
        end
        ST_REFRESH: begin
          if (r_ref_cnt == LAST_REF) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
          end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_idle      = r_idle;
  assign mem_ack       = r_ack;
  assign mem_data_next = r_next;
  assign ram_we        = r_we;
  assign ram_addr      = r_addr;
  assign ram_wdata     = r_wdata;
  assign bursts_done   = r_bursts;

endmodule

// File: tb/tb_mem_wr_responder.sv
// Directed bench: default-period instance for burst tests, 16-cycle-period
// instance for refresh interaction; scoreboard checks every RAM write.
module tb_mem_wr_responder;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [24:0] addr;
  logic [31:0] wdata;
  logic        sel;

  logic        a_idle, a_ack, a_next, a_we;
  logic [22:0] a_addr;
  logic [31:0] a_wdata;
  logic [15:0] a_bursts;
  logic        b_idle, b_ack, b_next, b_we;
  logic [22:0] b_addr;
  logic [31:0] b_wdata;
  logic [15:0] b_bursts;

  logic        idle_m, ack_m, next_m, we_m;
  logic [22:0] addr_m;
  logic [31:0] wdata_m;
  logic [15:0] bursts_m;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int n_we = 0, n_ack = 0, n_next = 0;
  logic [54:0] sb[$];
  logic [31:0] wq[$];

  always #5 mem_clk = ~mem_clk;

  mem_wr_responder u_dut_a (
    .mem_clk(mem_clk), .rst_n(rst_n), .mem_wr_req(req), .mem_wr_addr(addr),
    .mem_wr_data(wdata), .mem_idle(a_idle), .mem_ack(a_ack), .mem_data_next(a_next),
    .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wdata), .bursts_done(a_bursts)
  );

  mem_wr_responder #(.REFRESH_PERIOD(16), .REFRESH_LEN(4)) u_dut_b (
    .mem_clk(mem_clk), .rst_n(rst_n), .mem_wr_req(req), .mem_wr_addr(addr),
    .mem_wr_data(wdata), .mem_idle(b_idle), .mem_ack(b_ack), .mem_data_next(b_next),
    .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata), .bursts_done(b_bursts)
  );

  assign idle_m   = sel ? b_idle   : a_idle;
  assign ack_m    = sel ? b_ack    : a_ack;
  assign next_m   = sel ? b_next   : a_next;
  assign we_m     = sel ? b_we     : a_we;
  assign addr_m   = sel ? b_addr   : a_addr;
  assign wdata_m  = sel ? b_wdata  : a_wdata;
  assign bursts_m = sel ? b_bursts : a_bursts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed RAM write is matched against the next expected word.
  initial begin : monitor
    logic [54:0] e;
    forever begin
      @(negedge mem_clk);
      if (rst_n) begin
        if (ack_m)  n_ack++;
        if (next_m) n_next++;
        if (we_m) begin
          n_we++;
          chk("sb_nonempty_at_write", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ram_addr", 32'(addr_m), 32'(e[54:32]));
            chk("ram_wdata", wdata_m, e[31:0]);
          end
        end
      end
    end
  end

  // Writer model: presents the next word one cycle after each fetch strobe.
  initial begin : writer
    forever begin
      @(negedge mem_clk);
      if (rst_n && (ack_m || next_m)) begin
        @(posedge mem_clk);
        #1;
        if (wq.size() > 0) wdata = wq.pop_front();
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    repeat (2) @(posedge mem_clk);
    sb.delete();
    wq.delete();
    n_we = 0; n_ack = 0; n_next = 0;
    @(negedge mem_clk);
    rst_n = 1'b1;
  endtask

  task automatic push_burst(input logic [24:0] a, input logic [31:0] d0);
    logic [22:0] b;
    b = a[24:2];
    for (int k = 0; k < 4; k++) begin
      sb.push_back({b + 23'(k), d0 + 32'(k)});
      wq.push_back(d0 + 32'(k));
    end
  endtask

  task automatic run_burst(input logic [24:0] a, input logic [31:0] d0, input bit drop,
                           output int cyc);
    push_burst(a, d0);
    addr = a;
    req  = 1'b1;
    cyc  = 0;
    do begin
      @(posedge mem_clk);
      #1;
      cyc++;
      if (cyc == 1 && drop) req = 1'b0;
    end while (!idle_m && cyc < 40);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!idle_m && n < 40) begin
      @(posedge mem_clk);
      #1;
      n++;
    end
    repeat (2) @(negedge mem_clk);
  endtask

  initial begin : main
    int cyc, k, lo, k_ack;
    logic [24:0] b2b_addr [3];
    b2b_addr[0] = 25'h1000;
    b2b_addr[1] = 25'h2003;
    b2b_addr[2] = 25'h3000;
    sel = 1'b0; rst_n = 1'b0; req = 1'b0; addr = '0; wdata = '0;

    repeat (2) @(posedge mem_clk);
    #1;
    chk("rst_idle", 32'(idle_m), 32'd1);
    chk("rst_ack", 32'(ack_m), 32'd0);
    chk("rst_next", 32'(next_m), 32'd0);
    chk("rst_we", 32'(we_m), 32'd0);
    chk("rst_addr", 32'(addr_m), 32'd0);
    chk("rst_wdata", wdata_m, 32'd0);
    chk("rst_bursts", 32'(bursts_m), 32'd0);
    @(negedge mem_clk);
    rst_n = 1'b1;
    @(negedge mem_clk);
    chk("idle_after_release", 32'(idle_m), 32'd1);

    // Single burst at byte address 0x40.
    run_burst(25'h40, 32'hA0, 1'b1, cyc);
    chk("single_latency", 32'(cyc), 32'd6);
    repeat (2) @(negedge mem_clk);
    chk("single_bursts", 32'(bursts_m), 32'd1);
    chk("single_writes", 32'(n_we), 32'd4);
    chk("single_acks", 32'(n_ack), 32'd1);
    chk("single_data_next", 32'(n_next), 32'd3);
    chk("single_sb_empty", 32'(sb.size()), 32'd0);

    // Request pulsed mid-burst must be ignored.
    @(posedge mem_clk); #1;
    push_burst(25'h100, 32'hB0);
    addr = 25'h100; req = 1'b1;
    @(posedge mem_clk); #1; req = 1'b0;
    @(posedge mem_clk); #1;
    @(posedge mem_clk); #1; req = 1'b1; addr = 25'h200;
    @(posedge mem_clk); #1; req = 1'b0;
    wait_idle();
    repeat (4) @(negedge mem_clk);
    chk("busy_req_bursts", 32'(bursts_m), 32'd2);
    chk("busy_req_writes", 32'(n_we), 32'd8);

    // Three back-to-back bursts with the request held high.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      run_burst(b2b_addr[b], 32'h100 + 32'(b * 16), (b == 2), cyc);
      chk("b2b_latency", 32'(cyc), 32'd6);
    end
    repeat (2) @(negedge mem_clk);
    chk("b2b_bursts", 32'(bursts_m), 32'd3);
    chk("b2b_acks", 32'(n_ack), 32'd3);
    chk("b2b_data_next", 32'(n_next), 32'd9);
    chk("b2b_writes", 32'(n_we), 32'd12);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // 23-bit word address wrap.
    run_burst(25'h1FFFFF8, 32'hC0, 1'b1, cyc);
    chk("wrap_latency", 32'(cyc), 32'd6);
    repeat (2) @(negedge mem_clk);
    chk("wrap_bursts", 32'(bursts_m), 32'd4);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Reset asserted during beat 2 aborts the burst.
    do_reset();
    push_burst(25'h80, 32'hD0);
    addr = 25'h80; req = 1'b1;
    @(posedge mem_clk); #1; req = 1'b0;
    chk("abort_ack", 32'(ack_m), 32'd1);
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we_low", 32'(we_m), 32'd0);
    chk("abort_writes", 32'(n_we), 32'd2);
    chk("abort_unwritten", 32'(sb.size()), 32'd2);
    @(posedge mem_clk);
    @(negedge mem_clk);
    rst_n = 1'b1;
    sb.delete();
    wq.delete();
    @(negedge mem_clk);
    chk("abort_idle", 32'(idle_m), 32'd1);
    chk("abort_bursts", 32'(bursts_m), 32'd0);
    repeat (4) @(negedge mem_clk);
    chk("abort_no_more_writes", 32'(n_we), 32'd2);

    // Request raised on the same cycle refresh becomes pending: refresh first.
    sel = 1'b1;
    do_reset();
    repeat (16) @(posedge mem_clk);
    #1;
    push_burst(25'h400, 32'hE0);
    addr = 25'h400; req = 1'b1;
    k = 0; lo = 0; k_ack = 0;
    while (k_ack == 0 && k < 30) begin
      @(posedge mem_clk); #1;
      k++;
      if (ack_m) k_ack = k;
      else if (!idle_m) lo++;
    end
    req = 1'b0;
    chk("collide_ack_cycle", 32'(k_ack), 32'd6);
    chk("collide_refresh_len", 32'(lo), 32'd4);
    wait_idle();
    chk("collide_bursts", 32'(bursts_m), 32'd1);
    chk("collide_sb_empty", 32'(sb.size()), 32'd0);

    // Timer wraps during beat 1: burst finishes, then refresh runs.
    do_reset();
    repeat (13) @(posedge mem_clk);
    #1;
    run_burst(25'h800, 32'hF0, 1'b1, cyc);
    chk("burst_refresh_latency", 32'(cyc), 32'd10);
    repeat (2) @(negedge mem_clk);
    chk("burst_refresh_bursts", 32'(bursts_m), 32'd1);
    chk("burst_refresh_writes", 32'(n_we), 32'd4);
    chk("burst_refresh_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
